ram_sp_clr: RTL and testbench

- Parametrised single-port synchronous RAM, successor to the fixed 32x3 registered-input memory.
- Registered input stage, registered read data with a valid strobe, and a hardware clear engine that fills the array with CLEAR_VALUE after reset or on request.
- Used as scratch or lookup storage by lab datapaths; shields downstream logic from power-up contents.

---
 rtl/ram_sp_clr.sv | 122 ++++++++++++
 tb/tb_ram_sp_clr.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with a registered input stage, registered read data
// and a hardware clear engine. Optional RAM_WRITE_THROUGH_EN: writes also drive dataOut.
module ram_sp_clr #(
  parameter int                    DATA_WIDTH  = 3,
  parameter int                    ADDR_WIDTH  = 5,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  write,
  input  logic                  read,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataOutValid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic                  clr_q, clr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign busy = (state_q == ST_CLEAR) | clr_q;

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = address;
    din_d        = dataIn;
    wr_d         = write & ~busy;
    rd_d         = read  & ~busy;
    clr_d        = clear & ~busy;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = addr_q;
    mem_wdata    = din_q;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = CLEAR_VALUE;
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        // A sampled clear discards any write/read captured alongside it.
        if (clr_q) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (wr_q) begin
          mem_we = 1'b1;
`ifdef RAM_WRITE_THROUGH_EN
          dout_d       = din_q;
          dout_valid_d = 1'b1;
`endif
        end else if (rd_q) begin
          dout_d       = mem[addr_q];
          dout_valid_d = 1'b1;
        end
      end
    endcase

    // Reset restarts the clear engine but leaves the array alone while asserted.
    if (Reset) begin
      state_d      = ST_CLEAR;
      cnt_d        = '0;
      wr_d         = 1'b0;
      rd_d         = 1'b0;
      clr_d        = 1'b0;
      dout_d       = '0;
      dout_valid_d = 1'b0;
      mem_we       = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    cnt_q        <= cnt_d;
    addr_q       <= addr_d;
    din_q        <= din_d;
    wr_q         <= wr_d;
    rd_q         <= rd_d;
    clr_q        <= clr_d;
    dout_q       <= dout_d;
    dout_valid_q <= dout_valid_d;
  end

  // NOTE: the array has no reset; the clear engine is what initialises its contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign dataOut      = dout_q;
  assign dataOutValid = dout_valid_q;

endmodule

// File: tb/tb_ram_sp_clr.sv
// Scoreboard bench for ram_sp_clr: expected read data and arrival edge are queued
// at issue time and a negedge monitor pops and compares whenever dataOutValid is high.
module tb_ram_sp_clr;

  localparam int DW = 3;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          Reset;
  logic [AW-1:0] address;
  logic [DW-1:0] dataIn;
  logic          write, read, clear;
  logic [DW-1:0] dataOut;
  logic          dataOutValid;
  logic          busy;

  ram_sp_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_VALUE('0)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .address      (address),
    .dataIn       (dataIn),
    .write        (write),
    .read         (read),
    .clear        (clear),
    .dataOut      (dataOut),
    .dataOutValid (dataOutValid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every valid strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && dataOutValid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(dataOut), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("rd_data", 32'(dataOut), 32'(e.data));
          check("rd_edge", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    address = a;
    read    = 1'b1;
    tick();
    sb.push_back('{exp, cyc + 1});
    read = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    address = a;
    dataIn  = d;
    write   = 1'b1;
    tick();
`ifdef RAM_WRITE_THROUGH_EN
    sb.push_back('{d, cyc + 1});
`endif
    write = 1'b0;
  endtask

  // Counts edges until busy is observed low, bounded so a stuck busy still terminates.
  task automatic edges_until_idle(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1; address = '0; dataIn = '0; write = 1'b0; read = 1'b0; clear = 1'b0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 1);
    check("reset_dout", 32'(dataOut), 0);
    check("reset_valid", 32'(dataOutValid), 0);
    Reset  = 1'b0;
    mon_en = 1'b1;

    edges_until_idle(n);
    check("post_reset_clear_edges", n, 32);

    rd(5'd0, 3'b000);
    rd(5'd17, 3'b000);
    rd(5'd31, 3'b000);
    repeat (3) tick();

    // Write then read on the next cycle, then a second location.
    wr(5'd1, 3'b001);
    rd(5'd1, 3'b001);
    wr(5'd2, 3'b010);
    rd(5'd1, 3'b001);
    rd(5'd2, 3'b010);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) rd(5'd1, 3'b001);
      else            rd(5'd2, 3'b010);
    end
    repeat (3) tick();

    // Clear pulsed with a write: the write is dropped and writes/reads while busy are ignored.
    wr(5'd3, 3'b100);
    address = 5'd3; dataIn = 3'b111; write = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    read  = 1'b1;
    check("busy_after_clear_sample", 32'(busy), 1);
    edges_until_idle(n);
    write = 1'b0;
    read  = 1'b0;
    check("req_clear_edges", n, 33);
    for (int a = 0; a < 32; a++) rd(AW'(a), 3'b000);
    repeat (3) tick();

    // Reset while the clear counter is at 10 restarts the full clear.
    wr(5'd7, 3'b101);
    rd(5'd7, 3'b101);
    repeat (2) tick();
    check("dout_before_mid_reset", 32'(dataOut), 5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (11) tick();
    Reset = 1'b1;
    tick();
    check("mid_reset_busy", 32'(busy), 1);
    check("mid_reset_dout", 32'(dataOut), 0);
    Reset = 1'b0;
    edges_until_idle(n);
    check("mid_reset_clear_edges", n, 32);
    rd(5'd7, 3'b000);
    repeat (3) tick();

    // Simultaneous write and read to address 4.
    wr(5'd9, 3'b011);
    rd(5'd9, 3'b011);
    repeat (2) tick();
    address = 5'd4; dataIn = 3'b110; write = 1'b1; read = 1'b1;
    tick();
`ifdef RAM_WRITE_THROUGH_EN
    sb.push_back('{3'b110, cyc + 1});
`endif
    write = 1'b0;
    read  = 1'b0;
    repeat (2) tick();
`ifdef RAM_WRITE_THROUGH_EN
    check("wr_rd_dout", 32'(dataOut), 6);
`else
    check("wr_rd_dout", 32'(dataOut), 3);
`endif
    rd(5'd4, 3'b110);
    repeat (4) tick();

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
